// File: rtl/instruction_classify_pkg.sv
// Shared definitions for the instruction classification stage: category codes,
// decoded field positions and the opcode that selects function-field decoding.
package instruction_classify_pkg;

  localparam int CAT_W    = 4;
  localparam int NUM_CATS = 15;

  typedef enum logic [CAT_W-1:0] {
    CAT_OTHER   = 4'd0,
    CAT_RSHIFT  = 4'd1,
    CAT_RSHIFTV = 4'd2,
    CAT_RHILO   = 4'd3,
    CAT_RLONG   = 4'd4,
    CAT_RARITH  = 4'd5,
    CAT_RLOGIC  = 4'd6,
    CAT_RCOMP   = 4'd7,
    CAT_BRANCH  = 4'd8,
    CAT_JUMP    = 4'd9,
    CAT_ARITH   = 4'd10,
    CAT_COMP    = 4'd11,
    CAT_LOGIC   = 4'd12,
    CAT_STORE   = 4'd13,
    CAT_LOAD    = 4'd14,
    CAT_UNUSED  = 4'd15
  } category_t;

  localparam int OP_LSB   = 26;
  localparam int OP_W     = 6;
  localparam int FUNC_LSB = 0;
  localparam int FUNC_W   = 6;

  localparam logic [OP_W-1:0] OP_FUNC_SRC = 6'b000000;

endpackage

// File: rtl/instruction_classify_lane.sv
// Combinational decode of one instruction's op/func fields into a category
// code, plus a flag marking control-transfer instructions.
module instruction_classify_lane
  import instruction_classify_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  output category_t         category,
  output logic              ctrl
);

  category_t cat_next;

  always_comb begin
    cat_next = CAT_OTHER;
    if (op == OP_FUNC_SRC) begin
      casez (func)
        6'b0000??: cat_next = CAT_RSHIFT;
        6'b001???: cat_next = CAT_RSHIFT;
        6'b0001??: cat_next = CAT_RSHIFTV;
        6'b010???: cat_next = CAT_RHILO;
        6'b011???: cat_next = CAT_RLONG;
        6'b1000??: cat_next = CAT_RARITH;
        6'b1001??: cat_next = CAT_RLOGIC;
        6'b101???: cat_next = CAT_RCOMP;
        default:   cat_next = CAT_OTHER;
      endcase
    end else begin
      casez (op)
        6'b000001: cat_next = CAT_BRANCH;
        6'b0001??: cat_next = CAT_BRANCH;
        6'b00001?: cat_next = CAT_JUMP;
        6'b00100?: cat_next = CAT_ARITH;
        6'b00101?: cat_next = CAT_COMP;
        6'b0011??: cat_next = CAT_LOGIC;
        6'b101???: cat_next = CAT_STORE;
        6'b100???: cat_next = CAT_LOAD;
        default:   cat_next = CAT_OTHER;
      endcase
    end
  end

  assign category = cat_next;
  assign ctrl     = (cat_next == CAT_BRANCH) || (cat_next == CAT_JUMP);

endmodule

// File: rtl/instruction_classify_stage.sv
// Multi-lane registered classifier with a two-entry skid buffer and optional
// per-category saturating counters (enabled by INSTRUCTION_CLASSIFY_COUNTERS_EN).
module instruction_classify_stage
  import instruction_classify_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*WORD_W-1:0]   in_instr,
  input  logic [LANES-1:0]          in_mask,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WORD_W-1:0]   out_instr,
  output logic [LANES-1:0]          out_mask,
  output logic [LANES*CAT_W-1:0]    out_category,
  output logic                      out_ctrl,
  input  logic                      cnt_clear,
  input  logic [CAT_W-1:0]          cnt_sel,
  output logic [CNT_W-1:0]          cnt_value
);

  genvar gi;

  category_t                  lane_cat [LANES];
  logic [LANES-1:0]           lane_ctrl;
  logic [LANES*CAT_W-1:0]     in_category;
  logic                       in_ctrl;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      instruction_classify_lane u_lane (
        .op       (in_instr[gi*WORD_W + OP_LSB +: OP_W]),
        .func     (in_instr[gi*WORD_W + FUNC_LSB +: FUNC_W]),
        .category (lane_cat[gi]),
        .ctrl     (lane_ctrl[gi])
      );
      assign in_category[gi*CAT_W +: CAT_W] = in_mask[gi] ? lane_cat[gi] : CAT_OTHER;
    end
  endgenerate

  assign in_ctrl = |(lane_ctrl & in_mask);

  logic                       out_valid_reg;
  logic [LANES*WORD_W-1:0]    out_instr_reg;
  logic [LANES-1:0]           out_mask_reg;
  logic [LANES*CAT_W-1:0]     out_category_reg;
  logic                       out_ctrl_reg;

  logic                       skid_valid_reg;
  logic [LANES*WORD_W-1:0]    skid_instr_reg;
  logic [LANES-1:0]           skid_mask_reg;
  logic [LANES*CAT_W-1:0]     skid_category_reg;
  logic                       skid_ctrl_reg;

  logic accept;
  logic out_drain;

  assign in_ready  = ~skid_valid_reg;
  assign accept    = in_valid & in_ready;
  assign out_drain = ~out_valid_reg | out_ready;

  // The skid entry can only be occupied while in_ready is low, so a draining
  // output never has to take a skid bundle and a new bundle in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg     <= 1'b0;
      out_instr_reg     <= '0;
      out_mask_reg      <= '0;
      out_category_reg  <= '0;
      out_ctrl_reg      <= 1'b0;
      skid_valid_reg    <= 1'b0;
      skid_instr_reg    <= '0;
      skid_mask_reg     <= '0;
      skid_category_reg <= '0;
      skid_ctrl_reg     <= 1'b0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (out_drain) begin
      if (skid_valid_reg) begin
        out_valid_reg    <= 1'b1;
        out_instr_reg    <= skid_instr_reg;
        out_mask_reg     <= skid_mask_reg;
        out_category_reg <= skid_category_reg;
        out_ctrl_reg     <= skid_ctrl_reg;
        skid_valid_reg   <= 1'b0;
      end else begin
        out_valid_reg <= accept;
        if (accept) begin
          out_instr_reg    <= in_instr;
          out_mask_reg     <= in_mask;
          out_category_reg <= in_category;
          out_ctrl_reg     <= in_ctrl;
        end
      end
    end else if (accept) begin
      skid_valid_reg    <= 1'b1;
      skid_instr_reg    <= in_instr;
      skid_mask_reg     <= in_mask;
      skid_category_reg <= in_category;
      skid_ctrl_reg     <= in_ctrl;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_instr    = out_instr_reg;
  assign out_mask     = out_mask_reg;
  assign out_category = out_category_reg;
  assign out_ctrl     = out_ctrl_reg;

`ifdef INSTRUCTION_CLASSIFY_COUNTERS_EN
  localparam int HIT_W = 4;
  localparam int SUM_W = CNT_W + HIT_W;

  logic             count_en;
  logic [CNT_W-1:0] cnt_bank [NUM_CATS+1];

  assign count_en = out_valid_reg & out_ready & ~flush;

  generate
    for (gi = 0; gi < NUM_CATS; gi++) begin : g_cnt
      logic [HIT_W-1:0] hits;
      logic [SUM_W-1:0] sum;
      logic [CNT_W-1:0] cnt_reg;

      always_comb begin
        hits = '0;
        for (int li = 0; li < LANES; li++) begin
          if (out_mask_reg[li] && (out_category_reg[li*CAT_W +: CAT_W] == 4'(gi)))
            hits = hits + HIT_W'(1);
        end
      end

      assign sum = {{HIT_W{1'b0}}, cnt_reg} + {{CNT_W{1'b0}}, hits};

      // Any carry past CNT_W means the counter has hit its ceiling.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          cnt_reg <= '0;
        else if (cnt_clear)
          cnt_reg <= '0;
        else if (count_en)
          cnt_reg <= (|sum[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end

      assign cnt_bank[gi] = cnt_reg;
    end
  endgenerate

  assign cnt_bank[NUM_CATS] = '0;
  assign cnt_value = cnt_bank[cnt_sel];
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = ^{cnt_clear, cnt_sel};
  assign cnt_value = '0;
`endif

endmodule
